multi_cycle_core: RTL

//  Parametrised multi-cycle RV32I-subset core, successor to the single-cycle top.
//  One shared memory port carries both instruction fetch and load/store traffic, using a req/ack handshake.
//  A state machine sequences FETCH/DECODE/EXEC/MEM/WB, which tolerates wait-stated memory.

---
 rtl/multi_cycle_core.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle RV32I-subset core.
// One req/ack memory port is shared by instruction fetch and load/store.
module multi_cycle_core #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            retire,
    output logic [XLEN-1:0] pc_o,
    output logic            trap
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [XLEN-1:0] STEP = 4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_ADDI, K_LW, K_SW, K_BEQ, K_JAL
    } kind_t;

    state_t          state;
    kind_t           kind;
    kind_t           dec_kind;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr;
    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] dec_imm, alu_r, pc4;

    logic [6:0]    op, f7;
    logic [2:0]    f3;
    logic [4:0]    rs1, rs2, rd;
    logic [RW-1:0] rs1_i, rs2_i, rd_i;
    logic          legal, use_rs1, use_rs2, use_rd, bad_reg;

    assign op    = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign rs1_i = rs1[RW-1:0];
    assign rs2_i = rs2[RW-1:0];
    assign rd_i  = rd[RW-1:0];
    assign pc4   = pc + STEP;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

    // Instruction decode: class, legality, used fields and immediate.
    always_comb begin
        legal    = 1'b1;
        dec_kind = K_ALU;
        use_rs1  = 1'b1;
        use_rs2  = 1'b0;
        use_rd   = 1'b1;
        dec_imm  = {{(XLEN-12){ir[31]}}, ir[31:20]};
        unique case (op)
            7'b0110011: begin
                use_rs2 = 1'b1;
                legal   = (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 ||
                                           f3 == 3'd6 || f3 == 3'd2)) ||
                          (f7 == 7'h20 && f3 == 3'd0);
            end
            7'b0010011: begin
                dec_kind = K_ADDI;
                legal    = (f3 == 3'd0);
            end
            7'b0000011: begin
                dec_kind = K_LW;
                legal    = (f3 == 3'd2);
            end
            7'b0100011: begin
                dec_kind = K_SW;
                use_rs2  = 1'b1;
                use_rd   = 1'b0;
                legal    = (f3 == 3'd2);
                dec_imm  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            end
            7'b1100011: begin
                dec_kind = K_BEQ;
                use_rs2  = 1'b1;
                use_rd   = 1'b0;
                legal    = (f3 == 3'd0);
                dec_imm  = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
                            ir[30:25], ir[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_kind = K_JAL;
                use_rs1  = 1'b0;
                dec_imm  = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12],
                            ir[20], ir[30:21], 1'b0};
            end
            default: legal = 1'b0;
        endcase
        bad_reg = (use_rs1 && 32'(rs1) >= 32'(NREGS)) ||
                  (use_rs2 && 32'(rs2) >= 32'(NREGS)) ||
                  (use_rd  && 32'(rd)  >= 32'(NREGS));
    end

    // ALU: register ops for R-type, address/immediate add otherwise.
    always_comb begin
        alu_r = a + imm;
        if (kind == K_ALU) begin
            unique case (f3)
                3'd0:    alu_r = f7[5] ? a - b : a + b;
                3'd7:    alu_r = a & b;
                3'd6:    alu_r = a | b;
                3'd2:    alu_r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                default: alu_r = a + b;
            endcase
        end
    end

    // Sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            kind    <= K_ALU;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata[31:0];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rf[rs1_i];
                    b     <= rf[rs2_i];
                    imm   <= dec_imm;
                    kind  <= dec_kind;
                    state <= (legal && !bad_reg) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    unique case (kind)
                        K_BEQ: begin
                            pc    <= align((a == b) ? pc + imm : pc4);
                            state <= S_FETCH;
                        end
                        K_JAL: begin
                            alu_out <= pc4;
                            pc      <= align(pc + imm);
                            state   <= S_WB;
                        end
                        K_LW, K_SW: begin
                            alu_out <= alu_r;
                            state   <= S_MEM;
                        end
                        default: begin
                            alu_out <= alu_r;
                            state   <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (kind == K_SW) begin
                            pc    <= align(pc4);
                            state <= S_FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd_i != '0)
                        rf[rd_i] <= (kind == K_LW) ? mdr : alu_out;
                    if (kind != K_JAL)
                        pc <= align(pc4);
                    state <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

    assign mem_req   = rst && (state == S_FETCH || state == S_MEM);
    assign mem_we    = (state == S_MEM) && (kind == K_SW);
    assign mem_addr  = (state == S_MEM) ? {alu_out[XLEN-1:2], 2'b00} : pc;
    assign mem_wdata = b;
    assign retire    = (state == S_WB) ||
                       (state == S_EXEC && kind == K_BEQ) ||
                       (state == S_MEM && kind == K_SW && mem_ack);
    assign pc_o      = pc;
    assign trap      = (state == S_TRAP);

endmodule
